// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared rotor types, wirings, notches and FSM states
package enigma_pkg;

  typedef logic [4:0] letter_t;

  typedef enum logic [1:0] {IDLE, STEP, SUB, HOLD} state_e;

  typedef enum logic [1:0] {ROTOR_I, ROTOR_II, ROTOR_III} rotor_sel_e;

  localparam int NOTCH_I   = 16;
  localparam int NOTCH_II  = 4;
  localparam int NOTCH_III = 21;

  // EKMFLGDQVZNTOWYHXUSPAIBRCJ
  localparam letter_t WIRING_I [26] = '{
    5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25,
    5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15,
    5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9
  };

  // AJDKSIRUXBLHWTMCQGZNPYFVOE
  localparam letter_t WIRING_II [26] = '{
    5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,
    5'd11, 5'd7,  5'd22, 5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13,
    5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4
  };

  // BDFHJLCPRTXVZNYEIWGAKMUSQO
  localparam letter_t WIRING_III [26] = '{
    5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19,
    5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,
    5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14
  };

  // Single conditional subtract; valid for any input up to 51.
  function automatic letter_t mod26(input logic [5:0] v);
    logic [5:0] r;
    r = (v >= 6'd26) ? (v - 6'd26) : v;
    return r[4:0];
  endfunction

endpackage

// File: rtl/rotor_fwd_sub.sv
// rtl/rotor_fwd_sub.sv - one rotor substitution on the forward path
module rotor_fwd_sub
  import enigma_pkg::*;
(
  input  letter_t    letter,
  input  letter_t    pos,
  input  rotor_sel_e sel,
  output letter_t    result
);

  letter_t idx;
  letter_t wired;

  always_comb begin
    idx = mod26({1'b0, letter} + {1'b0, pos});
    case (sel)
      ROTOR_I:   wired = WIRING_I[idx];
      ROTOR_II:  wired = WIRING_II[idx];
      ROTOR_III: wired = WIRING_III[idx];
      default:   wired = WIRING_I[idx];
    endcase
    // Bias by 26 before subtracting so the difference never goes negative.
    result = mod26(({1'b0, wired} + 6'd26) - {1'b0, pos});
  end

endmodule

// File: rtl/forward_rotation_engine_f.sv
// rtl/forward_rotation_engine_f.sv - rotor stepping plus forward r1->r2->r3 substitution
module forward_rotation_engine_f
  import enigma_pkg::*;
#(
  parameter int R1_NOTCH = NOTCH_III,
  parameter int R2_NOTCH = NOTCH_II,
  parameter int R3_NOTCH = NOTCH_I
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] r1_pos_init,
  input  logic [4:0] r2_pos_init,
  input  logic [4:0] r3_pos_init,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] data_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] r1_out,
  output logic [4:0] r2_out,
  output logic [4:0] r3_out,
  output logic [4:0] r1_pos_F,
  output logic [4:0] r2_pos_F,
  output logic [4:0] r3_pos_F
);

  if (R1_NOTCH < 0 || R1_NOTCH > 25 || R2_NOTCH < 0 || R2_NOTCH > 25 ||
      R3_NOTCH < 0 || R3_NOTCH > 25) begin : g_bad_notch
    $error("rotor notch parameter out of range 0..25");
  end

  localparam letter_t N1 = letter_t'(R1_NOTCH);
  localparam letter_t N2 = letter_t'(R2_NOTCH);

  state_e  state_q;
  state_e  state_d;
  letter_t letter_q;
  letter_t sub1;
  letter_t sub2;
  letter_t sub3;

  function automatic letter_t inc26(input letter_t p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!load && in_valid) state_d = STEP;
      STEP:    state_d = SUB;
      SUB:     state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == HOLD);
  end

  rotor_fwd_sub u_r1 (.letter(letter_q), .pos(r1_pos_F), .sel(ROTOR_III), .result(sub1));
  rotor_fwd_sub u_r2 (.letter(sub1),     .pos(r2_pos_F), .sel(ROTOR_II),  .result(sub2));
  rotor_fwd_sub u_r3 (.letter(sub2),     .pos(r3_pos_F), .sel(ROTOR_I),   .result(sub3));

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_pos_F <= '0;
      r2_pos_F <= '0;
      r3_pos_F <= '0;
      letter_q <= '0;
      r1_out   <= '0;
      r2_out   <= '0;
      r3_out   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            r1_pos_F <= mod26({1'b0, r1_pos_init});
            r2_pos_F <= mod26({1'b0, r2_pos_init});
            r3_pos_F <= mod26({1'b0, r3_pos_init});
          end else if (in_valid) begin
            letter_q <= mod26({1'b0, data_in});
          end
        end
        STEP: begin
          // Middle rotor double-steps: it advances on its own notch as well as r1's.
          r1_pos_F <= inc26(r1_pos_F);
          if (r1_pos_F == N1 || r2_pos_F == N2) r2_pos_F <= inc26(r2_pos_F);
          if (r2_pos_F == N2) r3_pos_F <= inc26(r3_pos_F);
        end
        SUB: begin
          r1_out <= sub1;
          r2_out <= sub2;
          r3_out <= sub3;
        end
        default: ;
      endcase
    end
  end

endmodule
